// File: rtl/data_memory_store_buffer.sv
// rtl/data_memory_store_buffer.sv - in-order store buffer between stage 4 and data memory
// Optional store-to-load forwarding is enabled by defining STORE_FORWARD_EN.
module data_memory_store_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [XLEN-1:0]          st_addr,
    input  logic [XLEN-1:0]          st_data,
    input  logic [1:0]               st_size,
    output logic                     st_misaligned,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [XLEN-1:0]          mem_addr,
    output logic [XLEN-1:0]          mem_wdata,
    output logic [XLEN/8-1:0]        mem_be,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    input  logic [XLEN-1:0]          ld_addr,
    output logic                     ld_hit,
    output logic [XLEN-1:0]          ld_data,
    output logic                     ld_conflict
);
    localparam int NB = XLEN / 8;
    localparam int LW = $clog2(NB);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [XLEN-1:0] LANE_MASK = XLEN'(NB - 1);

    logic [XLEN-1:0] r_addr [DEPTH];
    logic [XLEN-1:0] r_data [DEPTH];
    logic [NB-1:0]   r_be   [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic [LW-1:0]   w_lane;
    logic            w_bad;
    logic [NB-1:0]   w_be_base;
    logic [XLEN-1:0] w_dmask;
    logic [XLEN-1:0] w_wdata;
    logic [NB-1:0]   w_be;
    logic [XLEN-1:0] w_st_aligned;
    logic [XLEN-1:0] w_ld_aligned;
    logic            w_full;
    logic            w_valid;
    logic            w_push;
    logic            w_pop;
    logic            w_any;
    logic [PW-1:0]   w_idx [DEPTH];

    assign w_lane = st_addr[LW-1:0];

    always_comb begin
        w_bad     = 1'b0;
        w_be_base = NB'(1);
        case (st_size)
            2'b00: begin
                w_bad     = 1'b0;
                w_be_base = NB'(1);
            end
            2'b01: begin
                w_bad     = st_addr[0];
                w_be_base = NB'(3);
            end
            2'b10: begin
                w_bad     = |st_addr[1:0];
                w_be_base = NB'(15);
            end
            default: begin
                w_bad     = (XLEN == 32) || (|st_addr[2:0]);
                w_be_base = '1;
            end
        endcase
    end

    for (genvar b = 0; b < NB; b++) begin : g_dmask
        assign w_dmask[8*b +: 8] = {8{w_be_base[b]}};
    end

    // Sub-word values keep only their low bytes, then move to the addressed lane.
    assign w_wdata      = (st_data & w_dmask) << {w_lane, 3'b000};
    assign w_be         = w_be_base << w_lane;
    assign w_st_aligned = st_addr & ~LANE_MASK;
    assign w_ld_aligned = ld_addr & ~LANE_MASK;

    assign st_misaligned = st_valid && w_bad;
    assign w_full        = (r_count == CW'(DEPTH));
    assign st_ready      = !reset && !w_full;
    assign w_valid       = !reset && (r_count != '0);
    assign w_push        = st_valid && st_ready && !w_bad;
    assign w_pop         = w_valid && mem_req_ready;

    assign mem_req_valid = w_valid;
    assign count         = reset ? '0 : r_count;
    assign empty         = !w_valid;
    assign mem_addr      = w_valid ? r_addr[r_rd_ptr] : '0;
    assign mem_wdata     = w_valid ? r_data[r_rd_ptr] : '0;
    assign mem_be        = w_valid ? r_be[r_rd_ptr]   : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= w_st_aligned;
            r_data[r_wr_ptr] <= w_wdata;
            r_be[r_wr_ptr]   <= w_be;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_idx
        assign w_idx[k] = r_rd_ptr + PW'(k);
    end

`ifdef STORE_FORWARD_EN
    logic [NB-1:0]   w_best_be;
    logic [XLEN-1:0] w_best_data;

    // Scan oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        w_any       = 1'b0;
        w_best_be   = '0;
        w_best_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!reset && (CW'(k) < r_count) && (r_addr[w_idx[k]] == w_ld_aligned)) begin
                w_any       = 1'b1;
                w_best_be   = r_be[w_idx[k]];
                w_best_data = r_data[w_idx[k]];
            end
        end
    end

    assign ld_hit      = w_any && (&w_best_be);
    assign ld_data     = ld_hit ? w_best_data : '0;
    assign ld_conflict = w_any && !(&w_best_be);
`else
    always_comb begin
        w_any = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!reset && (CW'(k) < r_count) && (r_addr[w_idx[k]] == w_ld_aligned))
                w_any = 1'b1;
        end
    end

    assign ld_hit      = 1'b0;
    assign ld_data     = '0;
    assign ld_conflict = w_any;
`endif

endmodule

// File: tb/tb_data_memory_store_buffer.sv
// tb/tb_data_memory_store_buffer.sv - randomized self-checking bench for data_memory_store_buffer
module tb_data_memory_store_buffer;
    logic        clk;
    logic        reset;

    logic        s_valid;
    logic [31:0] s_addr;
    logic [31:0] s_data;
    logic [1:0]  s_size;
    logic        mr_ready;
    logic [31:0] l_addr;
    logic        st_ready;
    logic        st_mis;
    logic        mv;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mbe;
    logic [2:0]  cnt;
    logic        emp;
    logic        lhit;
    logic [31:0] ldata;
    logic        lconf;

    logic        t_valid;
    logic [63:0] t_addr;
    logic [63:0] t_data;
    logic [1:0]  t_size;
    logic        t_mr_ready;
    logic [63:0] t_ld_addr;
    logic        t_st_ready;
    logic        t_mis;
    logic        t_mv;
    logic [63:0] t_maddr;
    logic [63:0] t_mwdata;
    logic [7:0]  t_mbe;
    logic [2:0]  t_cnt;
    logic        t_emp;
    logic        t_lhit;
    logic [63:0] t_ldata;
    logic        t_lconf;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
    } ent_t;
    ent_t q[$];

    data_memory_store_buffer #(.XLEN(32), .DEPTH(4)) u_dut32 (
        .clk(clk), .reset(reset),
        .st_valid(s_valid), .st_ready(st_ready), .st_addr(s_addr), .st_data(s_data),
        .st_size(s_size), .st_misaligned(st_mis),
        .mem_req_valid(mv), .mem_req_ready(mr_ready), .mem_addr(maddr),
        .mem_wdata(mwdata), .mem_be(mbe), .count(cnt), .empty(emp),
        .ld_addr(l_addr), .ld_hit(lhit), .ld_data(ldata), .ld_conflict(lconf)
    );

    data_memory_store_buffer #(.XLEN(64), .DEPTH(4)) u_dut64 (
        .clk(clk), .reset(reset),
        .st_valid(t_valid), .st_ready(t_st_ready), .st_addr(t_addr), .st_data(t_data),
        .st_size(t_size), .st_misaligned(t_mis),
        .mem_req_valid(t_mv), .mem_req_ready(t_mr_ready), .mem_addr(t_maddr),
        .mem_wdata(t_mwdata), .mem_be(t_mbe), .count(t_cnt), .empty(t_emp),
        .ld_addr(t_ld_addr), .ld_hit(t_lhit), .ld_data(t_ldata), .ld_conflict(t_lconf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference rules: alignment is addr modulo access size; lane is addr modulo bus bytes.
    function automatic bit ref_mis(input logic [63:0] a, input logic [1:0] sz, input int xlen);
        int bytes = 1 << sz;
        return ((a % bytes) != 0) || (bytes * 8 > xlen);
    endfunction

    function automatic logic [63:0] ref_be(input logic [63:0] a, input logic [1:0] sz, input int nb);
        int bytes = 1 << sz;
        int lane  = int'(a % nb);
        return ((64'd1 << bytes) - 64'd1) << lane;
    endfunction

    function automatic logic [63:0] ref_data(input logic [63:0] a, input logic [63:0] d,
                                             input logic [1:0] sz, input int nb);
        int bytes = 1 << sz;
        int lane  = int'(a % nb);
        logic [63:0] m;
        m = (bytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * bytes)) - 64'd1);
        return (d & m) << (8 * lane);
    endfunction

    // One clock of the 32-bit buffer: drive, check against the queue model, then advance it.
    task automatic cycle32(input bit v, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] sz, input bit rdy, input logic [31:0] la);
        bit          mis;
        bit          push;
        bit          pop;
        bit          any;
        logic [7:0]  ybe;
        logic [63:0] ydat;
        ent_t        e;
        s_valid  = v;
        s_addr   = a;
        s_data   = d;
        s_size   = sz;
        mr_ready = rdy;
        l_addr   = la;
        @(negedge clk);
        mis = ref_mis(64'(a), sz, 32);
        check("st_ready", st_ready, q.size() < 4);
        check("st_misaligned", st_mis, v && mis);
        check("mem_req_valid", mv, q.size() > 0);
        check("mem_addr", maddr, (q.size() > 0) ? q[0].addr : 64'd0);
        check("mem_wdata", mwdata, (q.size() > 0) ? q[0].data : 64'd0);
        check("mem_be", mbe, (q.size() > 0) ? 64'(q[0].be) : 64'd0);
        check("count", cnt, q.size());
        check("empty", emp, q.size() == 0);
        any  = 1'b0;
        ybe  = '0;
        ydat = '0;
        foreach (q[i]) begin
            if (q[i].addr == 64'(la & ~32'd3)) begin
                any  = 1'b1;
                ybe  = q[i].be;
                ydat = q[i].data;
            end
        end
`ifdef STORE_FORWARD_EN
        check("ld_hit", lhit, any && ybe == 8'h0F);
        check("ld_data", ldata, (any && ybe == 8'h0F) ? ydat : 64'd0);
        check("ld_conflict", lconf, any && ybe != 8'h0F);
`else
        check("ld_hit", lhit, 0);
        check("ld_data", ldata, ydat & 64'd0);
        check("ld_conflict", lconf, any);
`endif
        push   = v && !mis && (q.size() < 4);
        pop    = (q.size() > 0) && rdy;
        e.addr = 64'(a & ~32'd3);
        e.data = ref_data(64'(a), 64'(d), sz, 4) & 64'hFFFF_FFFF;
        e.be   = 8'(ref_be(64'(a), sz, 4));
        @(posedge clk);
        #1;
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(e);
    endtask

    initial begin
        reset = 1'b1;
        s_valid = 0; s_addr = '0; s_data = '0; s_size = '0; mr_ready = 0; l_addr = '0;
        t_valid = 0; t_addr = '0; t_data = '0; t_size = '0; t_mr_ready = 0; t_ld_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        s_valid = 1; s_addr = 32'h100; l_addr = 32'h100;
        @(negedge clk);
        check("rst_st_ready", st_ready, 0);
        check("rst_mem_req_valid", mv, 0);
        check("rst_count", cnt, 0);
        check("rst_empty", emp, 1);
        check("rst_ld_hit", lhit, 0);
        check("rst_ld_conflict", lconf, 0);
        check("rst_st_ready64", t_st_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0; s_valid = 0;
        @(negedge clk);
        check("ready_after_reset", st_ready, 1);
        check("ready_after_reset64", t_st_ready, 1);
        @(posedge clk);
        #1;

        // sb to top lane of a word, not visible until the following cycle
        cycle32(1, 32'h103, 32'hAABBCCDD, 2'b00, 0, 32'h0);
        check("sb_mem_addr", maddr, 64'h100);
        check("sb_mem_be", mbe, 64'h8);
        check("sb_mem_wdata", mwdata, 64'hDD00_0000);
        for (int i = 0; i < 3; i++) cycle32(0, 0, 0, 0, 1, 0);

        // five back-to-back stores into a stalled memory, then drain in order
        for (int i = 0; i < 5; i++) cycle32(1, 32'h110 + 32'(4 * i), 32'h1000 + 32'(i), 2'b10, 0, 32'h110);
        check("full_count", cnt, 4);
        check("full_st_ready", st_ready, 0);
        cycle32(1, 32'h124, 32'h1004, 2'b10, 1, 32'h0);
        cycle32(1, 32'h124, 32'h1004, 2'b10, 1, 32'h0);
        for (int i = 0; i < 6; i++) cycle32(0, 0, 0, 0, 1, 32'h124);

        // two held, then simultaneous enqueue and dequeue
        cycle32(1, 32'h130, 32'hA, 2'b10, 0, 0);
        cycle32(1, 32'h134, 32'hB, 2'b10, 0, 0);
        cycle32(1, 32'h138, 32'hC, 2'b10, 1, 0);
        check("simul_count", cnt, 2);
        for (int i = 0; i < 3; i++) cycle32(0, 0, 0, 0, 1, 0);

        // forwarding / conflict on a repeated word address
        cycle32(1, 32'h200, 32'h1111_1111, 2'b10, 0, 32'h200);
        cycle32(1, 32'h200, 32'h2222_2222, 2'b10, 0, 32'h200);
        cycle32(0, 0, 0, 0, 0, 32'h200);
        cycle32(1, 32'h201, 32'h33, 2'b00, 0, 32'h202);
        cycle32(0, 0, 0, 0, 0, 32'h200);

        // reset with three held entries discards them all
        cycle32(0, 0, 0, 0, 0, 0);
        s_valid = 0; mr_ready = 0;
        check("pre_reset_count", cnt, 3);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_mem_req_valid", mv, 0);
        check("midrst_count", cnt, 0);
        check("midrst_mem_be", mbe, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        for (int i = 0; i < 2; i++) cycle32(0, 0, 0, 0, 1, 32'h200);

        // XLEN=64 half-word lane placement and misalignment drop
        t_valid = 1; t_addr = 64'h6; t_data = 64'h1234; t_size = 2'b01; t_mr_ready = 0;
        @(negedge clk);
        check("sh64_misaligned", t_mis, 0);
        check("sh64_not_yet_valid", t_mv, 0);
        @(posedge clk);
        #1;
        t_addr = 64'h2; t_size = 2'b10;
        @(negedge clk);
        check("sh64_mem_be", t_mbe, 64'hC0);
        check("sh64_mem_wdata", t_mwdata, 64'h1234_0000_0000_0000);
        check("sh64_mem_addr", t_maddr, 64'h0);
        check("sw64_misaligned", t_mis, 1);
        @(posedge clk);
        #1;
        t_addr = 64'h10; t_size = 2'b11; t_data = 64'h0102_0304_0506_0708;
        @(negedge clk);
        check("sw64_count_unchanged", t_cnt, 1);
        check("sd64_misaligned", t_mis, 0);
        @(posedge clk);
        #1;
        t_valid = 0; t_mr_ready = 1;
        @(negedge clk);
        check("sd64_count", t_cnt, 2);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("sd64_mem_be", t_mbe, 64'hFF);
        check("sd64_mem_wdata", t_mwdata, 64'h0102_0304_0506_0708);
        @(posedge clk);
        #1;
        t_mr_ready = 0;

        // randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            cycle32(($urandom % 4) != 0, 32'h100 + $urandom_range(0, 31), $urandom,
                    2'($urandom % 4), ($urandom % 3) == 0, 32'h100 + $urandom_range(0, 31));
        end
        for (int i = 0; i < 6; i++) cycle32(0, 0, 0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/data_memory_store_buffer.md
DATA_MEMORY_STORE_BUFFER -- requirements
Module: data_memory_store_buffer

Interface
REQ-001 Parameter XLEN, default 32, data/address width; legal values 32 or 64.
REQ-002 Parameter DEPTH, default 4, store entries; power of two, 2..16.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 st_valid  input  1  store request from stage 4.
REQ-006 st_ready  output  1  buffer can accept a store.
REQ-007 st_addr  input  XLEN  byte address of store.
REQ-008 st_data  input  XLEN  register value; low bytes used for sub-word sizes.
REQ-009 st_size  input  2  00 byte, 01 hword, 10 word, 11 dword.
REQ-010 st_misaligned  output  1  current request is misaligned or illegal.
REQ-011 mem_req_valid  output  1  head entry presented to data memory.
REQ-012 mem_req_ready  input  1  memory accepts head entry this cycle.
REQ-013 mem_addr  output  XLEN  head address, low log2(XLEN/8) bits zero.
REQ-014 mem_wdata  output  XLEN  head data, lane-placed.
REQ-015 mem_be  output  XLEN/8  head byte-enable mask.
REQ-016 count  output  clog2(DEPTH)+1  occupied entries.
REQ-017 empty  output  1  count == 0.
REQ-018 ld_addr  input  XLEN  load address for hazard check.
REQ-019 ld_hit  output  1  forwarded data is valid.
REQ-020 ld_data  output  XLEN  forwarded data.
REQ-021 ld_conflict  output  1  load must stall until buffer drains the overlap.

Function
REQ-022 Misaligned: hword with addr[0]!=0, word with addr[1:0]!=0, dword with addr[2:0]!=0, or st_size=11 when XLEN=32; st_misaligned combinational, asserted only while st_valid is high.
REQ-023 Lane placement: byte lane = addr[log2(XLEN/8)-1:0]; value shifted left by 8*lane bits; mem_be has 1/2/4/8 contiguous ones starting at lane; unused data lanes are 0, never X.
REQ-024 st_ready = !full, independent of st_valid and mem_req_ready; no bypass on full.
REQ-025 Enqueue on st_valid && st_ready && !st_misaligned; misaligned stores are dropped, with no state change.
REQ-026 An enqueued entry is visible on mem_req_* no earlier than the next cycle; minimum store-to-memory latency is 1 cycle.
REQ-027 mem_req_valid = !empty; dequeue head on mem_req_valid && mem_req_ready; mem_addr/wdata/be are stable while valid && !ready.
REQ-028 Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
REQ-029 Read/write pointers wrap modulo DEPTH; full when count == DEPTH.
REQ-030 When empty, mem_addr, mem_wdata and mem_be are driven 0.
REQ-031 Memory ordering is strict FIFO; entries are never merged or reordered.

Reset
REQ-032 While reset is high: count=0, empty=1, pointers=0, mem_req_valid=0, st_ready=0, ld_hit=0, ld_conflict=0.
REQ-033 Reset mid-operation discards all entries, including a head held in an unaccepted handshake; no further memory write occurs for them.
REQ-034 st_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-035 Macro STORE_FORWARD_EN: when defined, match valid entries on ld_addr aligned to XLEN/8 and select the youngest match. If its mem_be is all ones: ld_hit=1 and ld_data = its data, ld_conflict=0. If a match exists but the youngest is partial: ld_hit=0, ld_conflict=1. Both outputs are combinational.
REQ-036 When STORE_FORWARD_EN is undefined: ld_hit=0, ld_data=0, ld_conflict=1 if any valid entry matches, and no forwarding logic is built.

Verification
REQ-037 XLEN=32, sb addr 0x103, data 0xAABBCCDD -> next cycle mem_addr 0x100, mem_be 1000, mem_wdata 0xDD000000.
REQ-038 XLEN=64, sh addr 0x6 data 0x1234 -> mem_be 0xC0, mem_wdata 0x1234_0000_0000_0000; sw addr 0x2 -> st_misaligned=1, count unchanged.
REQ-039 DEPTH=4, mem_req_ready=0, 5 stores back to back -> st_ready=0 after the 4th, the 5th is held, count=4; release ready -> stores drain in order, pointers wrap.
REQ-040 count=2, simultaneous enqueue and dequeue -> count stays 2, the new entry appears 2 dequeues later.
REQ-041 Buffer holds 3 entries with mem_req_ready=0, assert reset 1 cycle -> empty=1, mem_req_valid=0 the next cycle, and no writes to memory.
REQ-042 With STORE_FORWARD_EN: sw 0x200=0x11111111, then sw 0x200=0x22222222, ld_addr 0x200 -> ld_hit=1, ld_data 0x22222222; add sb 0x201 -> ld_conflict=1, ld_hit=0.
